// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the in-order
// writeback stage and out-of-order late results (divider, uncached loads).
// Late results queue in a small FIFO. The pipe normally wins the port. The FIFO head
// steals the port, stalling writeback, when the FIFO is full or the head has starved.
// Optional feature: define WB_ARB_BYPASS_EN so that a late result goes straight to the
// regfile when the FIFO is empty and the pipe is idle.
module wb_port_arbiter #(
   parameter int unsigned FIFO_DEPTH   = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  pipe_wren_i,
   input  logic [4:0]  pipe_waddr_i,
   input  logic [31:0] pipe_wdata_i,
   input  logic [31:0] pipe_pc_i,
   input  logic        late_valid_i,
   output logic        late_ready_o,
   input  logic [3:0]  late_wren_i,
   input  logic [4:0]  late_waddr_i,
   input  logic [31:0] late_wdata_i,
   input  logic [31:0] late_pc_i,
   output logic [3:0]  rf_wren_o,
   output logic [4:0]  rf_waddr_o,
   output logic [31:0] rf_wdata_o,
   output logic        wb_stallreq_o,
   output logic [31:0] debug_wb_pc,
   output logic [3:0]  debug_wb_rf_wen,
   output logic [4:0]  debug_wb_rf_wnum,
   output logic [31:0] debug_wb_rf_wdata
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned PTR_AW = PTR_W + 1;
   localparam int unsigned CNT_W  = 4;

   typedef struct packed {
      logic [3:0]  wren;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [31:0] pc;
   } wb_entry_t;

   wb_entry_t         mem [FIFO_DEPTH];
   logic [PTR_AW-1:0] wr_ptr;
   logic [PTR_AW-1:0] rd_ptr;
   logic [CNT_W-1:0]  starve_cnt;

   logic      full;
   logic      empty;
   logic      preq;
   logic      freq;
   logic      starved;
   logic      fgnt;
   logic      pgnt;
   logic      bypass;
   logic      push;
   wb_entry_t head;
   wb_entry_t late_entry;
   wb_entry_t pipe_entry;
   wb_entry_t sel;

   assign full  = (wr_ptr[PTR_AW-1] != rd_ptr[PTR_AW-1]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign head  = mem[rd_ptr[PTR_W-1:0]];

   assign late_entry = '{wren: late_wren_i, waddr: late_waddr_i,
                         wdata: late_wdata_i, pc: late_pc_i};
   assign pipe_entry = '{wren: pipe_wren_i, waddr: pipe_waddr_i,
                         wdata: pipe_wdata_i, pc: pipe_pc_i};

   // Port grant; no regfile write is issued while reset is held, so entries
   // pending at reset are dropped rather than written.
   always_comb begin
      preq    = |pipe_wren_i;
      freq    = !empty;
      starved = (starve_cnt == CNT_W'(STARVE_LIMIT));
      fgnt    = rst_n && freq && (!preq || full || starved);
      pgnt    = rst_n && preq && !fgnt;
`ifdef WB_ARB_BYPASS_EN
      bypass  = rst_n && empty && !preq && late_valid_i && (|late_wren_i);
`else
      bypass  = 1'b0;
`endif
      push    = late_valid_i && !full && (|late_wren_i) && !bypass;
   end

   // Output mux: FIFO head, pipe fields, bypassed late result, or all zero.
   always_comb begin
      sel = '0;
      if (fgnt) begin
         sel = head;
      end else if (pgnt) begin
         sel = pipe_entry;
      end else if (bypass) begin
         sel = late_entry;
      end
   end

   assign late_ready_o      = !full;
   assign wb_stallreq_o     = fgnt && preq;
   assign rf_wren_o         = sel.wren;
   assign rf_waddr_o        = sel.waddr;
   assign rf_wdata_o        = sel.wdata;
   assign debug_wb_pc       = sel.pc;
   assign debug_wb_rf_wen   = sel.wren;
   assign debug_wb_rf_wnum  = sel.waddr;
   assign debug_wb_rf_wdata = sel.wdata;

   // FIFO pointers and head starvation counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         starve_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_AW'(1);
         end
         if (fgnt) begin
            rd_ptr <= rd_ptr + PTR_AW'(1);
         end
         if (fgnt || empty) begin
            starve_cnt <= '0;
         end else if (freq && pgnt && !starved) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
         end
      end
   end

   // FIFO storage; contents are qualified by the pointers and need no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[PTR_W-1:0]] <= late_entry;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: a queue-based model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_wb_port_arbiter;

   localparam int unsigned FIFO_DEPTH   = 2;
   localparam int unsigned STARVE_LIMIT = 4;

   typedef struct packed {
      logic [3:0]  wren;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [31:0] pc;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  pipe_wren = '0;
   logic [4:0]  pipe_waddr = '0;
   logic [31:0] pipe_wdata = '0;
   logic [31:0] pipe_pc = '0;
   logic        late_valid = 1'b0;
   logic        late_ready;
   logic [3:0]  late_wren = '0;
   logic [4:0]  late_waddr = '0;
   logic [31:0] late_wdata = '0;
   logic [31:0] late_pc = '0;
   logic [3:0]  rf_wren;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        wb_stallreq;
   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;

   int checks = 0;
   int passed = 0;

   wb_port_arbiter #(
      .FIFO_DEPTH   (FIFO_DEPTH),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .pipe_wren_i       (pipe_wren),
      .pipe_waddr_i      (pipe_waddr),
      .pipe_wdata_i      (pipe_wdata),
      .pipe_pc_i         (pipe_pc),
      .late_valid_i      (late_valid),
      .late_ready_o      (late_ready),
      .late_wren_i       (late_wren),
      .late_waddr_i      (late_waddr),
      .late_wdata_i      (late_wdata),
      .late_pc_i         (late_pc),
      .rf_wren_o         (rf_wren),
      .rf_waddr_o        (rf_waddr),
      .rf_wdata_o        (rf_wdata),
      .wb_stallreq_o     (wb_stallreq),
      .debug_wb_pc       (debug_wb_pc),
      .debug_wb_rf_wen   (debug_wb_rf_wen),
      .debug_wb_rf_wnum  (debug_wb_rf_wnum),
      .debug_wb_rf_wdata (debug_wb_rf_wdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   ent_t q[$];
   int   lost = 0;
   bit   armed = 1'b0;
   bit   m_preq, m_full, m_fg, m_pg, m_byp;
   ent_t m_exp;

   // Each negedge: predict outputs from the queue, compare, then advance the
   // model to the state it will hold after the coming rising edge.
   always @(negedge clk) begin
      m_preq = (pipe_wren != 4'h0);
      m_full = (q.size() == int'(FIFO_DEPTH));
      m_fg   = rst_n && (q.size() != 0) && (!m_preq || m_full || lost == int'(STARVE_LIMIT));
      m_pg   = rst_n && m_preq && !m_fg;
      m_byp  = 1'b0;
`ifdef WB_ARB_BYPASS_EN
      m_byp  = rst_n && (q.size() == 0) && !m_preq && late_valid && (late_wren != 4'h0);
`endif
      m_exp = '0;
      if (m_fg)       m_exp = q[0];
      else if (m_pg)  m_exp = '{pipe_wren, pipe_waddr, pipe_wdata, pipe_pc};
      else if (m_byp) m_exp = '{late_wren, late_waddr, late_wdata, late_pc};

      if (armed) begin
         chk("model_ready",  32'(late_ready),        32'(!m_full));
         chk("model_stall",  32'(wb_stallreq),       32'(m_fg && m_preq));
         chk("model_rfwren", 32'(rf_wren),           32'(m_exp.wren));
         chk("model_dbgpc",  debug_wb_pc,            m_exp.pc);
         chk("model_dbgwen", 32'(debug_wb_rf_wen),   32'(m_exp.wren));
         chk("model_dbgnum", 32'(debug_wb_rf_wnum),  32'(m_exp.waddr));
         chk("model_dbgdat", debug_wb_rf_wdata,      m_exp.wdata);
         if (m_exp.wren != 4'h0) begin
            chk("model_rfaddr", 32'(rf_waddr), 32'(m_exp.waddr));
            chk("model_rfdata", rf_wdata,      m_exp.wdata);
         end
      end

      if (!rst_n) begin
         q.delete();
         lost  = 0;
         armed = 1'b1;
      end else begin
         if (m_fg) begin
            void'(q.pop_front());
            lost = 0;
         end else if (q.size() == 0) begin
            lost = 0;
         end else if (m_pg && lost < int'(STARVE_LIMIT)) begin
            lost++;
         end
         if (late_valid && !m_full && late_wren != 4'h0 && !m_byp)
            q.push_back('{late_wren, late_waddr, late_wdata, late_pc});
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic set_pipe(input logic [3:0] w, input logic [4:0] a,
                           input logic [31:0] d, input logic [31:0] p);
      pipe_wren = w; pipe_waddr = a; pipe_wdata = d; pipe_pc = p;
   endtask

   task automatic set_late(input logic v, input logic [3:0] w, input logic [4:0] a,
                           input logic [31:0] d, input logic [31:0] p);
      late_valid = v; late_wren = w; late_waddr = a; late_wdata = d; late_pc = p;
   endtask

   task automatic idle();
      set_pipe(4'h0, 5'd0, 32'h0, 32'h0);
      set_late(1'b0, 4'h0, 5'd0, 32'h0, 32'h0);
   endtask

   initial begin
      // 1: reset with idle inputs
      idle();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      settle();
      chk("t1_rfwren", 32'(rf_wren), 32'h0);
      chk("t1_stall",  32'(wb_stallreq), 32'h0);
      chk("t1_ready",  32'(late_ready), 32'h1);
      chk("t1_dbgpc",  debug_wb_pc, 32'h0);
      chk("t1_dbgwen", 32'(debug_wb_rf_wen), 32'h0);
      chk("t1_dbgnum", 32'(debug_wb_rf_wnum), 32'h0);
      chk("t1_dbgdat", debug_wb_rf_wdata, 32'h0);
      step();

      // 2: late write into an idle pipe, then a zero-enable late result is discarded
      set_late(1'b1, 4'hF, 5'd5, 32'hDEAD_BEEF, 32'hBFC0_0100);
      settle();
`ifdef WB_ARB_BYPASS_EN
      chk("t2_bypass_wren", 32'(rf_wren), 32'hF);
      chk("t2_bypass_addr", 32'(rf_waddr), 32'd5);
`else
      chk("t2_c0_wren", 32'(rf_wren), 32'h0);
`endif
      chk("t2_c0_stall", 32'(wb_stallreq), 32'h0);
      step();
      set_late(1'b1, 4'h0, 5'd6, 32'h1234, 32'hBFC0_0104);
      settle();
`ifdef WB_ARB_BYPASS_EN
      chk("t2_c1_wren", 32'(rf_wren), 32'h0);
`else
      chk("t2_c1_wren", 32'(rf_wren), 32'hF);
      chk("t2_c1_addr", 32'(rf_waddr), 32'd5);
      chk("t2_c1_data", rf_wdata, 32'hDEAD_BEEF);
      chk("t2_c1_pc",   debug_wb_pc, 32'hBFC0_0100);
`endif
      chk("t2_c1_stall", 32'(wb_stallreq), 32'h0);
      step();
      idle();
      settle();
      chk("t2_discard_wren", 32'(rf_wren), 32'h0);
      chk("t2_ready", 32'(late_ready), 32'h1);
      step();

      // 3: starvation under continuous pipe writes to r1
      for (int i = 0; i < 7; i++) begin
         int j;
         j = (i == 6) ? 5 : i;
         set_pipe(4'hF, 5'd1, 32'h100 + 32'(j), 32'h1000 + 32'(4 * j));
         if (i == 0) set_late(1'b1, 4'hF, 5'd7, 32'h7777, 32'h2000);
         else        set_late(1'b0, 4'h0, 5'd0, 32'h0, 32'h0);
         settle();
         if (i <= 4) begin
            chk("t3_pipe_addr", 32'(rf_waddr), 32'd1);
            chk("t3_pipe_stall", 32'(wb_stallreq), 32'h0);
         end else if (i == 5) begin
            chk("t3_fifo_addr", 32'(rf_waddr), 32'd7);
            chk("t3_fifo_pc", debug_wb_pc, 32'h2000);
            chk("t3_fifo_stall", 32'(wb_stallreq), 32'h1);
         end else begin
            chk("t3_held_addr", 32'(rf_waddr), 32'd1);
            chk("t3_held_data", rf_wdata, 32'h105);
            chk("t3_held_stall", 32'(wb_stallreq), 32'h0);
         end
         step();
      end
      idle();
      step();

      // 4: fill the FIFO while the pipe writes; a third push waits for ready
      set_pipe(4'hF, 5'd2, 32'h22, 32'h4000);
      set_late(1'b1, 4'hF, 5'd8, 32'hA, 32'h3000);
      step();
      set_late(1'b1, 4'hF, 5'd9, 32'hB, 32'h3004);
      settle();
      chk("t4_c1_ready", 32'(late_ready), 32'h1);
      step();
      set_late(1'b1, 4'hF, 5'd10, 32'hC, 32'h3008);
      settle();
      chk("t4_full_ready", 32'(late_ready), 32'h0);
      chk("t4_full_stall", 32'(wb_stallreq), 32'h1);
      chk("t4_full_pc",    debug_wb_pc, 32'h3000);
      chk("t4_full_addr",  32'(rf_waddr), 32'd8);
      step();
      settle();
      chk("t4_c3_ready", 32'(late_ready), 32'h1);
      chk("t4_c3_stall", 32'(wb_stallreq), 32'h0);
      chk("t4_c3_addr",  32'(rf_waddr), 32'd2);
      step();
      set_late(1'b0, 4'h0, 5'd0, 32'h0, 32'h0);
      settle();
      chk("t4_c4_ready", 32'(late_ready), 32'h0);
      chk("t4_c4_stall", 32'(wb_stallreq), 32'h1);
      chk("t4_c4_pc",    debug_wb_pc, 32'h3004);
      step();
      settle();
      chk("t4_c5_stall", 32'(wb_stallreq), 32'h0);
      chk("t4_c5_addr",  32'(rf_waddr), 32'd2);
      step();
      idle();
      settle();
      chk("t4_c6_pc",    debug_wb_pc, 32'h3008);
      chk("t4_c6_stall", 32'(wb_stallreq), 32'h0);
      step();
      settle();
      chk("t4_c7_wren",  32'(rf_wren), 32'h0);
      chk("t4_c7_ready", 32'(late_ready), 32'h1);
      step();

      // 5: simultaneous push and pop at occupancy 1 keeps order
      set_pipe(4'hF, 5'd3, 32'h33, 32'h4100);
      set_late(1'b1, 4'hF, 5'd11, 32'hD, 32'h5000);
      step();
      set_pipe(4'h0, 5'd0, 32'h0, 32'h0);
      set_late(1'b1, 4'hF, 5'd12, 32'hE, 32'h5004);
      settle();
      chk("t5_c1_pc",    debug_wb_pc, 32'h5000);
      chk("t5_c1_ready", 32'(late_ready), 32'h1);
      step();
      set_late(1'b1, 4'hF, 5'd13, 32'hF, 32'h5008);
      settle();
      chk("t5_c2_pc",    debug_wb_pc, 32'h5004);
      chk("t5_c2_ready", 32'(late_ready), 32'h1);
      step();
      set_late(1'b0, 4'h0, 5'd0, 32'h0, 32'h0);
      settle();
      chk("t5_c3_pc", debug_wb_pc, 32'h5008);
      step();
      settle();
      chk("t5_c4_wren", 32'(rf_wren), 32'h0);
      step();

      // 6: reset with two entries pending
      set_pipe(4'hF, 5'd4, 32'h44, 32'h4200);
      set_late(1'b1, 4'hF, 5'd14, 32'h66, 32'h6000);
      step();
      set_late(1'b1, 4'hF, 5'd15, 32'h67, 32'h6004);
      settle();
      chk("t6_c1_ready", 32'(late_ready), 32'h1);
      step();
      idle();
      rst_n = 1'b0;
      settle();
      chk("t6_rst_wren",  32'(rf_wren), 32'h0);
      chk("t6_rst_stall", 32'(wb_stallreq), 32'h0);
      chk("t6_rst_ready", 32'(late_ready), 32'h0);
      step();
      rst_n = 1'b1;
      settle();
      chk("t6_post_ready", 32'(late_ready), 32'h1);
      chk("t6_post_wren",  32'(rf_wren), 32'h0);
      step();
      settle();
      chk("t6_post2_wren", 32'(rf_wren), 32'h0);
      step();
      step();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order writeback stage and late-arriving results, such as divider completions and uncached-load returns, which complete out of pipeline order. Late results are buffered in a small FIFO. The pipeline write normally has priority; the arbiter steals the port, and stalls writeback through the controller, when the FIFO fills or its head starves. It sits between `writeback`, the late-result producers and the regfile/debug trace outputs.

## Interface
Parameters:
- `FIFO_DEPTH`, 2: late-result buffer entries; power of two, ≥2.
- `STARVE_LIMIT`, 4: consecutive lost cycles before the FIFO head is forced through; 1–15.

Ports:
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `rst_n`  in  1  — reset; synchronous, active-low.
- `pipe_wren_i`  in  4  — writeback byte enables; nonzero means a write request.
- `pipe_waddr_i`  in  5  — writeback destination register.
- `pipe_wdata_i`  in  32  — writeback data.
- `pipe_pc_i`  in  32  — writeback PC.
- `late_valid_i`  in  1  — late result offered.
- `late_ready_o`  out  1  — FIFO can accept a result.
- `late_wren_i`  in  4  — late result byte enables.
- `late_waddr_i`  in  5  — late result destination register.
- `late_wdata_i`  in  32  — late result data.
- `late_pc_i`  in  32  — late result PC.
- `rf_wren_o`  out  4  — regfile write enables.
- `rf_waddr_o`  out  5  — regfile write address.
- `rf_wdata_o`  out  32  — regfile write data.
- `wb_stallreq_o`  out  1  — requests that the controller freeze the writeback stage.
- `debug_wb_pc`  out  32  — trace PC.
- `debug_wb_rf_wen`  out  4  — trace write enables.
- `debug_wb_rf_wnum`  out  5  — trace register number.
- `debug_wb_rf_wdata`  out  32  — trace data.

## Operation
- **FIFO:** `FIFO_DEPTH` entries, each holding {wren, waddr, wdata, pc}. It uses read and write pointers of log2(DEPTH)+1 bits. Full means the pointer MSBs differ and the lower bits are equal; empty means the pointers are equal. Both wrap naturally.
- **Enqueue:** `late_ready_o` = !full, decoded from registered pointers only. An entry is pushed when `late_valid_i` && `late_ready_o`. A late result with `late_wren_i`==0 is accepted and discarded without being pushed.
- **Pipe request:** `preq` = |`pipe_wren_i`.
- **FIFO request:** `freq` = !empty.
- **Grant (combinational, each cycle):**
  - `fgnt` = `freq` && (!`preq` || full || `starve_cnt` == `STARVE_LIMIT`).
  - `pgnt` = `preq` && !`fgnt`.
- **Output mux:**
  - When `fgnt`, the regfile and debug outputs carry the FIFO head, and the read pointer advances.
  - When `pgnt`, the outputs carry the pipe fields.
  - Otherwise `rf_wren_o` = 0 and every debug output = 0.
  - `rf_waddr_o` and `rf_wdata_o` are don't-care when `rf_wren_o` = 0.
- **Stall:** `wb_stallreq_o` = `fgnt` && `preq`. The controller holds the writeback inputs stable, and the pipe request is presented again the next cycle.
- **Starvation counter `starve_cnt`** (4 bits):
  - Cleared on `fgnt` or when empty.
  - Incremented when `freq` && `pgnt`.
  - Saturates at `STARVE_LIMIT`.
- **Simultaneous push and pop:** legal in the same cycle; occupancy is unchanged.
- **Push while full:** impossible, because ready is low.
- **Ordering:** WAW and RAW hazards against pending late results are excluded by the decode-stage scoreboard. The arbiter does no address comparison.
- **Flush:** a pipeline flush does not touch the FIFO, because late results belong to committed instructions.

## Timing
- **Reset** (`rst_n`=0 at a clock edge): pointers and `starve_cnt` return to 0.
  - `late_ready_o` goes to 1 after reset, once the FIFO is empty.
  - `rf_wren_o`, `wb_stallreq_o` and all debug outputs read 0 while the FIFO is empty and `pipe_wren_i` = 0.
  - Reset mid-operation discards all buffered entries.
- **Pipe path:** combinational, zero latency. A pipe write reaches the regfile in the same cycle it is granted.
- **Late path:** at least 1 cycle. A result pushed at edge N can be written at the earliest in cycle N+1.
- **Worst-case late wait:** with continuous pipe writes, an entry at the head is written within `STARVE_LIMIT`+1 cycles. An entry at depth k waits at most k·(`STARVE_LIMIT`+1) cycles.
- **Stall length:** at most 1 cycle per granted FIFO entry. Back-to-back FIFO grants are possible only while full.

## Configuration
- **`WB_ARB_BYPASS_EN` defined:**
  - When the FIFO is empty, `preq`=0 and `late_valid_i`=1 with nonzero enables, the late result is written to the regfile in the same cycle and is not pushed.
  - `late_ready_o` is unaffected.
- **Not defined:** every late result passes through the FIFO, with a minimum of 1 cycle latency.

## Test plan
1. **Reset with idle inputs:** reset asserted for 2 cycles while inputs are idle → `rf_wren_o`=0, `wb_stallreq_o`=0, `late_ready_o`=1 and all debug outputs 0.
2. **Late write into an idle pipe:** push late {wren=F, waddr=5, wdata=0xDEAD_BEEF, pc=0xBFC0_0100} while the pipe is idle → regfile write of r5=0xDEADBEEF in the next cycle (same cycle with `WB_ARB_BYPASS_EN`), with no stall.
3. **Starvation under continuous pipe writes:** continuous pipe writes to r1, one late entry, `STARVE_LIMIT`=4 → pipe wins 4 cycles, then the FIFO entry is written in cycle 5 with `wb_stallreq_o`=1, then the held pipe write commits.
4. **Full FIFO:** fill the FIFO (2 pushes while the pipe writes) → `late_ready_o`=0 and the next cycle grants the FIFO with a stall. A third push offered while full is held until ready rises, and no entry is lost.
5. **Push and pop in one cycle:** simultaneous push and pop at occupancy 1 → occupancy stays 1 and FIFO order is preserved (trace PCs in push order).
6. **Reset mid-operation:** reset with 2 entries pending → the entries are never written, and `late_ready_o`=1 afterwards.
